watch_display_sequencer: RTL and testbench
==========================================

// Module: watch_display_sequencer
// PURPOSE
//   Front-end controller for the two-digit seven-segment display driver.
//   Shows the hours, minutes and seconds pages in turn on the one display.
//   Runs the time-set mode: the field being edited blinks, Up increments it,
//   and a commit strobe writes the edited time back to the time counter.
//   Sits between the time counter and the display driver: drives its Digits and Blink inputs.
// PARAMETERS
//   PAGE_TICKS    50_000_000  clocks per displayed page in show mode (1 s @ 50 MHz)
//   BLINK_TICKS   12_500_000  clocks per blink half-period in edit mode
//   EDIT_TIMEOUT  500_000_000 idle clocks in edit mode before abort (10 s)
// PORTS
//   Clk_50MHz  in   1  system clock; all state on rising edge
//   Reset      in   1  synchronous, active-high reset
//   Hours      in   5  live hours, 0..23
//   Minutes    in   6  live minutes, 0..59
//   Seconds    in   6  live seconds, 0..59
//   ModeBtn    in   1  debounced one-cycle pulse: enter edit / next field
//   UpBtn      in   1  debounced one-cycle pulse: increment edited field
//   Digits     out  7  value 0..99 to the display driver
//   Blink      out  1  blink enable to the display driver
//   Field      out  2  page shown: 0=HH 1=MM 2=SS (3 never driven)
//   Editing    out  1  high while in an EDIT state
//   SetLoad    out  1  one-cycle strobe: load SetH/SetM/SetS into the time counter
//   SetH/SetM/SetS out 5/6/6  edited time; valid when SetLoad=1
// BEHAVIOUR
//   Reset: state SHOW_HH; all counters 0; edit regs 0.
//     Outputs on reset: Digits=0, Blink=0, Field=0, Editing=0, SetLoad=0, SetH/M/S=0.
//   FSM states: SHOW_HH, SHOW_MM, SHOW_SS, EDIT_HH, EDIT_MM, EDIT_SS, COMMIT.
//   All outputs are registered. They reflect the state and inputs of the previous cycle (1-clk latency).
//   Show states:
//     - Digits = live field, zero-extended to 7 bits; Blink=0; Editing=0.
//     - Page counter counts 0..PAGE_TICKS-1.
//     - On the terminal count: SHOW_HH->SHOW_MM->SHOW_SS->SHOW_HH (wraps), and the counter returns to 0.
//   ModeBtn in any show state:
//     - go to EDIT_HH on the same edge;
//     - capture Hours/Minutes/Seconds into the edit regs;
//     - clear the blink and idle counters.
//   Edit states:
//     - Digits = edit reg of the field; Editing=1.
//     - Blink = blink phase: 0 for BLINK_TICKS clocks, then 1 for BLINK_TICKS clocks, repeating.
//       The phase starts at 0 on entry to each edit state.
//   UpBtn in an edit state:
//     - increments the edit reg, with wrap 23->0 (HH) and 59->0 (MM/SS);
//     - restarts the blink phase at 0 and clears the idle counter.
//   ModeBtn in an edit state:
//     - EDIT_HH->EDIT_MM->EDIT_SS->COMMIT;
//     - clears the idle counter and restarts the blink phase.
//   COMMIT lasts exactly 1 cycle:
//     - SetLoad=1 with SetH/M/S = edit regs;
//     - then SHOW_HH with the page counter at 0. SetLoad is 0 in every other state.
//   Timeout: EDIT_TIMEOUT consecutive clocks with no button in an edit state -> SHOW_HH.
//     No SetLoad is issued and the edit regs are discarded.
//   ModeBtn and UpBtn in the same cycle: ModeBtn wins and UpBtn is ignored (no increment).
//   Live inputs change during edit: ignored, because the edit regs are a snapshot.
//   Reset mid-edit or in COMMIT: immediate return to reset state. No SetLoad is issued.
// TESTING (bench params PAGE_TICKS=4, BLINK_TICKS=2, EDIT_TIMEOUT=16)
//   Reset, H=12 M=34 S=56, no buttons:
//     Digits 12 x4 clk, 34 x4, 56 x4, 12...; Field 0,1,2,0; Blink=0.
//   ModeBtn, then UpBtn x12 with H=12:
//     Editing=1, Digits 12..23,0; Blink pattern 0,0,1,1 after last Up.
//   Mode, Mode (MM=34), Up x26, Mode, Mode:
//     one SetLoad pulse with SetH=12 SetM=0 SetS=56; then Field=0, Editing=0.
//   Mode, then 16 idle clocks:
//     return to SHOW_HH with no SetLoad; Editing=0.
//   ModeBtn and UpBtn in the same cycle while in EDIT_HH at 5:
//     state goes to EDIT_MM; HH edit reg stays 5.
//   Reset asserted during EDIT_SS:
//     next cycle all outputs are at reset values; SetLoad never pulses.

Source files
------------

// File: rtl/watch_display_sequencer.sv
// Display front-end for the watch: pages HH/MM/SS in show mode and runs the
// blink/increment/commit time-set sequence. All outputs are registered.
module watch_display_sequencer #(
   parameter int PAGE_TICKS   = 50_000_000,
   parameter int BLINK_TICKS  = 12_500_000,
   parameter int EDIT_TIMEOUT = 500_000_000
) (
   input  logic       Clk_50MHz,
   input  logic       Reset,
   input  logic [4:0] Hours,
   input  logic [5:0] Minutes,
   input  logic [5:0] Seconds,
   input  logic       ModeBtn,
   input  logic       UpBtn,
   output logic [6:0] Digits,
   output logic       Blink,
   output logic [1:0] Field,
   output logic       Editing,
   output logic       SetLoad,
   output logic [4:0] SetH,
   output logic [5:0] SetM,
   output logic [5:0] SetS,
   output logic [2:0] o_dbg_state
);

   localparam int BLINK_PERIOD = 2 * BLINK_TICKS;
   localparam int PW = (PAGE_TICKS   > 1) ? $clog2(PAGE_TICKS)   : 1;
   localparam int BW = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
   localparam int IW = (EDIT_TIMEOUT > 1) ? $clog2(EDIT_TIMEOUT) : 1;

   localparam logic [PW-1:0] PAGE_LAST  = PW'(PAGE_TICKS - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_PERIOD - 1);
   localparam logic [BW-1:0] BLINK_HALF = BW'(BLINK_TICKS);
   localparam logic [IW-1:0] IDLE_LAST  = IW'(EDIT_TIMEOUT - 1);

   typedef enum logic [2:0] {
      SHOW_HH, SHOW_MM, SHOW_SS, EDIT_HH, EDIT_MM, EDIT_SS, COMMIT
   } state_t;

   state_t        r_state;
   logic [PW-1:0] r_page;
   logic [BW-1:0] r_blink;
   logic [IW-1:0] r_idle;
   logic [4:0]    r_edit_h;
   logic [5:0]    r_edit_m;
   logic [5:0]    r_edit_s;

   logic [6:0]    w_live;
   logic [6:0]    w_edit;
   logic [1:0]    w_field;
   logic          w_is_edit;
   logic          w_phase;

   // COMMIT falls through to the defaults: field 0 showing live hours.
   always_comb begin
      w_field = 2'd0;
      w_live  = {2'b00, Hours};
      w_edit  = {2'b00, r_edit_h};
      case (r_state)
         SHOW_MM, EDIT_MM: begin
            w_field = 2'd1;
            w_live  = {1'b0, Minutes};
            w_edit  = {1'b0, r_edit_m};
         end
         SHOW_SS, EDIT_SS: begin
            w_field = 2'd2;
            w_live  = {1'b0, Seconds};
            w_edit  = {1'b0, r_edit_s};
         end
         default: ;
      endcase
   end

   assign w_is_edit   = (r_state == EDIT_HH) || (r_state == EDIT_MM) || (r_state == EDIT_SS);
   assign w_phase     = (r_blink >= BLINK_HALF);
   assign o_dbg_state = r_state;

   always_ff @(posedge Clk_50MHz) begin
      if (Reset) begin
         r_state  <= SHOW_HH;
         r_page   <= '0;
         r_blink  <= '0;
         r_idle   <= '0;
         r_edit_h <= '0;
         r_edit_m <= '0;
         r_edit_s <= '0;
         Digits   <= '0;
         Blink    <= 1'b0;
         Field    <= 2'd0;
         Editing  <= 1'b0;
         SetLoad  <= 1'b0;
         SetH     <= '0;
         SetM     <= '0;
         SetS     <= '0;
      end else begin
         Digits  <= w_is_edit ? w_edit : w_live;
         Blink   <= w_is_edit & w_phase;
         Field   <= w_field;
         Editing <= w_is_edit;
         SetLoad <= 1'b0;
         case (r_state)
            SHOW_HH, SHOW_MM, SHOW_SS: begin
               if (ModeBtn) begin
                  r_state  <= EDIT_HH;
                  r_edit_h <= Hours;
                  r_edit_m <= Minutes;
                  r_edit_s <= Seconds;
                  r_blink  <= '0;
                  r_idle   <= '0;
                  r_page   <= '0;
               end else if (r_page == PAGE_LAST) begin
                  r_page <= '0;
                  case (r_state)
                     SHOW_HH: r_state <= SHOW_MM;
                     SHOW_MM: r_state <= SHOW_SS;
                     default: r_state <= SHOW_HH;
                  endcase
               end else begin
                  r_page <= r_page + PW'(1);
               end
            end
            EDIT_HH, EDIT_MM, EDIT_SS: begin
               // ModeBtn has priority, so a simultaneous UpBtn never increments.
               if (ModeBtn) begin
                  r_blink <= '0;
                  r_idle  <= '0;
                  case (r_state)
                     EDIT_HH: r_state <= EDIT_MM;
                     EDIT_MM: r_state <= EDIT_SS;
                     default: r_state <= COMMIT;
                  endcase
               end else if (UpBtn) begin
                  r_blink <= '0;
                  r_idle  <= '0;
                  case (r_state)
                     EDIT_HH: r_edit_h <= (r_edit_h == 5'd23) ? 5'd0 : r_edit_h + 5'd1;
                     EDIT_MM: r_edit_m <= (r_edit_m == 6'd59) ? 6'd0 : r_edit_m + 6'd1;
                     default: r_edit_s <= (r_edit_s == 6'd59) ? 6'd0 : r_edit_s + 6'd1;
                  endcase
               end else if (r_idle == IDLE_LAST) begin
                  r_state <= SHOW_HH;
                  r_page  <= '0;
                  r_idle  <= '0;
                  r_blink <= '0;
               end else begin
                  r_idle  <= r_idle + IW'(1);
                  r_blink <= (r_blink == BLINK_LAST) ? '0 : r_blink + BW'(1);
               end
            end
            COMMIT: begin
               SetLoad <= 1'b1;
               SetH    <= r_edit_h;
               SetM    <= r_edit_m;
               SetS    <= r_edit_s;
               r_state <= SHOW_HH;
               r_page  <= '0;
            end
            default: r_state <= SHOW_HH;
         endcase
      end
   end

endmodule

// File: tb/tb_watch_display_sequencer.sv
// Bench for watch_display_sequencer: directed scenarios then random buttons,
// checked cycle by cycle against a time-based reference model.
module tb_watch_display_sequencer;

   localparam int PAGE  = 4;
   localparam int BLINK = 2;
   localparam int TMO   = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] hours;
   logic [5:0] minutes, seconds;
   logic       mode_btn, up_btn;
   logic [6:0] digits;
   logic       blink, editing, set_load;
   logic [1:0] field;
   logic [4:0] set_h;
   logic [5:0] set_m, set_s;
   logic [2:0] dbg_state;

   typedef struct packed {
      logic [6:0] digits;
      logic       blink;
      logic [1:0] field;
      logic       editing;
      logic       setload;
      logic       chk_set;
      logic [4:0] sh;
      logic [5:0] sm;
      logic [5:0] ss;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   watch_display_sequencer #(
      .PAGE_TICKS(PAGE), .BLINK_TICKS(BLINK), .EDIT_TIMEOUT(TMO)
   ) dut (
      .Clk_50MHz(clk), .Reset(rst), .Hours(hours), .Minutes(minutes),
      .Seconds(seconds), .ModeBtn(mode_btn), .UpBtn(up_btn),
      .Digits(digits), .Blink(blink), .Field(field), .Editing(editing),
      .SetLoad(set_load), .SetH(set_h), .SetM(set_m), .SetS(set_s),
      .o_dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s t=%0t actual=%0d expected=%0d", name, $time, act, exp);
      end
   endtask

   // Reference model: mode 0=show, 1=edit, 2=commit. Page and blink are derived
   // from elapsed cycle counts rather than from explicit counters.
   initial begin : model
      int   mode, t_show, fld, ev, f;
      int   val[3];
      int   live[3];
      int   lim[3];
      exp_t e;
      lim[0] = 24; lim[1] = 60; lim[2] = 60;
      mode = 0; t_show = 0; fld = 0; ev = 0;
      val[0] = 0; val[1] = 0; val[2] = 0;
      forever begin
         @(posedge clk);
         e = '0;
         if (rst) begin
            mode = 0; t_show = 0; fld = 0; ev = 0;
            val[0] = 0; val[1] = 0; val[2] = 0;
            e.chk_set = 1'b1;
         end else begin
            live[0] = int'(hours); live[1] = int'(minutes); live[2] = int'(seconds);
            case (mode)
               0: begin
                  f = (t_show / PAGE) % 3;
                  e.field  = 2'(f);
                  e.digits = 7'(live[f]);
                  if (mode_btn) begin
                     mode = 1; fld = 0; ev = 0;
                     for (int i = 0; i < 3; i++) val[i] = live[i];
                  end else begin
                     t_show = (t_show + 1) % (3 * PAGE);
                  end
               end
               1: begin
                  e.field   = 2'(fld);
                  e.digits  = 7'(val[fld]);
                  e.editing = 1'b1;
                  e.blink   = 1'((ev / BLINK) % 2);
                  if (mode_btn) begin
                     ev = 0;
                     if (fld == 2) mode = 2;
                     else fld++;
                  end else if (up_btn) begin
                     val[fld] = (val[fld] + 1) % lim[fld];
                     ev = 0;
                  end else begin
                     ev++;
                     if (ev == TMO) begin
                        mode = 0; t_show = 0;
                     end
                  end
               end
               default: begin
                  e.field   = 2'd0;
                  e.digits  = 7'(live[0]);
                  e.setload = 1'b1;
                  e.chk_set = 1'b1;
                  e.sh = 5'(val[0]); e.sm = 6'(val[1]); e.ss = 6'(val[2]);
                  mode = 0; t_show = 0;
               end
            endcase
         end
         exp_q.push_back(e);
      end
   end

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("digits",  int'(digits),   int'(e.digits));
            check("blink",   int'(blink),    int'(e.blink));
            check("field",   int'(field),    int'(e.field));
            check("editing", int'(editing),  int'(e.editing));
            check("setload", int'(set_load), int'(e.setload));
            if (e.chk_set) begin
               check("set_h", int'(set_h), int'(e.sh));
               check("set_m", int'(set_m), int'(e.sm));
               check("set_s", int'(set_s), int'(e.ss));
            end
         end
      end
   end

   task automatic cyc(input logic m, input logic u);
      mode_btn = m;
      up_btn   = u;
      @(negedge clk);
      mode_btn = 1'b0;
      up_btn   = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(1'b0, 1'b0);
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin : stimulus
      int k;
      rst = 1'b1; mode_btn = 1'b0; up_btn = 1'b0;
      hours = 5'd12; minutes = 6'd34; seconds = 6'd56;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      idle(14);

      cyc(1'b1, 1'b0);
      hours = 5'd7;
      repeat (12) cyc(1'b0, 1'b1);
      idle(6);
      hours = 5'd12;
      idle(20);

      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      repeat (26) cyc(1'b0, 1'b1);
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      idle(4);

      cyc(1'b1, 1'b0);
      idle(16);
      idle(4);

      hours = 5'd0;
      cyc(1'b1, 1'b0);
      repeat (5) cyc(1'b0, 1'b1);
      cyc(1'b1, 1'b1);
      idle(3);
      cyc(1'b1, 1'b0);
      idle(2);
      pulse_reset();
      idle(5);

      for (int b = 0; b < 400; b++) begin
         if ($urandom_range(0, 3) == 0) begin
            hours   = 5'($urandom_range(0, 23));
            minutes = 6'($urandom_range(0, 59));
            seconds = 6'($urandom_range(0, 59));
         end
         k = $urandom_range(0, 9);
         case (k)
            0, 1: cyc(1'b1, 1'b0);
            2, 3: cyc(1'b0, 1'b1);
            4:    cyc(1'b1, 1'b1);
            5:    if ($urandom_range(0, 9) == 0) pulse_reset(); else cyc(1'b0, 1'b0);
            default: idle($urandom_range(1, 20));
         endcase
      end

      idle(3);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
